dff_write_arbiter: RTL

Round-robin write arbiter in front of a shared WIDTH-bit enabled data register. Up to NREQ requesters offer data over valid/ready handshakes. The block grants one requester per write, loads the winning data into the register, and then enforces a programmable hold window before the next write is accepted. It sits between the requesting logic and any consumer of the held register value.

---
 rtl/dff_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/dff_write_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/dff_arb_pkg.sv
// rtl/dff_arb_pkg.sv - shared types and helpers for the write arbiter
package dff_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Index width for n items, never below one bit so a 1-wide vector still exists.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot picker
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Search starts just above the previous winner and wraps, so the
    // previous winner itself is considered last.
    always_comb begin : pick
        int   pos;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = (int'(last_grant) + k) % NREQ;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IW'(pos);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/dff_write_arbiter.sv
// rtl/dff_write_arbiter.sv - round-robin write arbiter feeding a held data register
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*WIDTH-1:0]       req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic [WIDTH-1:0]            q,
    output logic [owner_w(NREQ)-1:0]    q_owner,
    output logic                        q_valid,
    output logic                        wr_pulse,
    output logic                        busy
);

    localparam int IW = owner_w(NREQ);
    localparam int CW = owner_w(HOLD_CYCLES + 1);
    localparam int HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   last_grant;
    logic [NREQ-1:0] win_onehot;
    logic [IW-1:0]   win_idx;
    logic            any_req;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (win_onehot),
        .idx        (win_idx),
        .any        (any_req)
    );

    // Grants only in IDLE; held off during reset so a write is never offered
    // on an edge that is going to discard it.
    assign req_ready = (state == IDLE && !rst) ? win_onehot : '0;
    assign busy      = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= IW'(NREQ - 1);
            q          <= '0;
            q_owner    <= '0;
            q_valid    <= 1'b0;
            wr_pulse   <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        q          <= req_data[win_idx*WIDTH +: WIDTH];
                        q_owner    <= win_idx;
                        q_valid    <= 1'b1;
                        wr_pulse   <= 1'b1;
                        last_grant <= win_idx;
                        if (HOLD_CYCLES > 0) begin
                            state <= HOLD;
                            cnt   <= CW'(HOLD_LOAD);
                        end
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
